// File: rtl/rd_ctrl_mb_if.sv
// rd_ctrl_mb_if: config, handshake and status bundle between the bank read controller and its environment.
interface rd_ctrl_mb_if #(
  parameter int ADDR_W = 9,
  parameter int BANK_W = 4,
  parameter int CYC_W  = 8
);
  logic              i_start;
  logic [BANK_W-1:0] i_cfg_bank_num;
  logic [CYC_W-1:0]  i_cfg_cyc_num;
  logic [ADDR_W-1:0] i_cfg_last_addr;
  logic              i_bank_prepare;
  logic              i_pull_back;
  logic              i_out_rdy;
  logic              o_out_val;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [2:0]        o_beat_idx_d;
  logic [BANK_W-1:0] o_bank_id;
  logic              o_bank_done;
  logic              o_all_done;
  logic [1:0]        o_state;
  modport master (
    output i_start, i_cfg_bank_num, i_cfg_cyc_num, i_cfg_last_addr, i_bank_prepare, i_pull_back, i_out_rdy,
    input  o_out_val, o_rd_en, o_rd_addr, o_beat_idx_d, o_bank_id, o_bank_done, o_all_done, o_state
  );
  modport slave (
    input  i_start, i_cfg_bank_num, i_cfg_cyc_num, i_cfg_last_addr, i_bank_prepare, i_pull_back, i_out_rdy,
    output o_out_val, o_rd_en, o_rd_addr, o_beat_idx_d, o_bank_id, o_bank_done, o_all_done, o_state
  );
endinterface

// File: rtl/rd_ctrl_mb.sv
// rd_ctrl_mb: multi-beat SRAM bank reader rotating over banks for a configured number of passes.
module rd_ctrl_mb #(
  parameter int ADDR_W = 9,
  parameter int BEATS  = 2,
  parameter int BANK_W = 4,
  parameter int CYC_W  = 8
) (
  input logic         clk,
  input logic         rst,
  rd_ctrl_mb_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, READY = 2'b01, READ = 2'b11} state_t;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
  state_t            r_state, w_next;
  logic [BANK_W-1:0] r_bank_num, r_bank_id;
  logic [CYC_W-1:0]  r_cyc_num, r_pass;
  logic [ADDR_W-1:0] r_last_addr, r_rd_addr;
  logic [2:0]        r_beat_cnt, r_beat_idx_d;
  logic              r_prep_d, r_all_done;
  logic              w_active, w_adv, w_beat_wrap, w_bank_done, w_bank_wrap;
  assign w_active    = r_state == READY || r_state == READ;
  assign w_adv       = bus.i_out_rdy & w_active & !bus.i_start;
  assign w_beat_wrap = r_beat_cnt == LAST_BEAT;
  // Address is compared before it increments, so last_addr = all-ones ends the bank without wrapping.
  assign w_bank_done = (w_adv & w_beat_wrap & r_rd_addr == r_last_addr) | (bus.i_pull_back & r_state != IDLE);
  assign w_bank_wrap = r_bank_id == r_bank_num - 1'b1;
  always_comb begin
    w_next = bus.i_start ? IDLE
           : r_state == IDLE ? ((bus.i_bank_prepare & r_prep_d & !r_all_done) ? READY : IDLE)
           : (w_bank_done || !w_active) ? IDLE
           : (r_state == READY && bus.i_out_rdy) ? READ : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prep_d     <= 1'b0;
      r_bank_num   <= BANK_W'(1);
      r_cyc_num    <= CYC_W'(1);
      r_last_addr  <= '0;
      r_rd_addr    <= '0;
      r_beat_cnt   <= '0;
      r_beat_idx_d <= '0;
      r_bank_id    <= '0;
      r_pass       <= '0;
      r_all_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_prep_d <= bus.i_bank_prepare;
      if (bus.i_start) begin
        r_bank_num  <= bus.i_cfg_bank_num == '0 ? BANK_W'(1) : bus.i_cfg_bank_num;
        r_cyc_num   <= bus.i_cfg_cyc_num == '0 ? CYC_W'(1) : bus.i_cfg_cyc_num;
        r_last_addr <= bus.i_cfg_last_addr;
        r_rd_addr   <= '0;
        r_beat_cnt  <= '0;
        r_bank_id   <= '0;
        r_pass      <= '0;
        r_all_done  <= 1'b0;
      end else begin
        if (w_adv) r_beat_idx_d <= r_beat_cnt;
        if (r_state == IDLE || w_bank_done) begin
          r_rd_addr  <= '0;
          r_beat_cnt <= '0;
        end else if (w_adv) begin
          r_beat_cnt <= w_beat_wrap ? 3'd0 : r_beat_cnt + 3'd1;
          if (w_beat_wrap) r_rd_addr <= r_rd_addr + 1'b1;
        end
        if (w_bank_done) begin
          r_bank_id <= w_bank_wrap ? '0 : r_bank_id + 1'b1;
          if (w_bank_wrap) r_pass <= r_pass + 1'b1;
          if (w_bank_wrap && r_pass == r_cyc_num - 1'b1) r_all_done <= 1'b1;
        end
      end
    end
  end
  assign bus.o_out_val    = r_state == READ;
  assign bus.o_rd_en      = w_adv & (r_beat_cnt == 3'd0);
  assign bus.o_rd_addr    = r_rd_addr;
  assign bus.o_beat_idx_d = r_beat_idx_d;
  assign bus.o_bank_id    = r_bank_id;
  assign bus.o_bank_done  = w_bank_done;
  assign bus.o_all_done   = r_all_done;
  assign bus.o_state      = r_state;
endmodule

// File: doc/rd_ctrl_mb.md
RD_CTRL_MB -- requirements
Module: rd_ctrl_mb

Interface
REQ-001 Parameter ADDR_W, default 9, SRAM word-address width.
REQ-002 Parameter BEATS, default 2, output beats per SRAM word, legal range 1..8.
REQ-003 Parameter BANK_W, default 4, bank-ID width.
REQ-004 Parameter CYC_W, default 8, pass-counter width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  pulse; latches configuration and aborts any activity.
REQ-008 cfg_bank_num  in  BANK_W  number of banks in rotation; 0 is treated as 1.
REQ-009 cfg_cyc_num  in  CYC_W  number of rotation passes; 0 is treated as 1.
REQ-010 cfg_last_addr  in  ADDR_W  last word address per bank; words read = value+1.
REQ-011 bank_prepare  in  1  current bank filled and readable.
REQ-012 pull_back  in  1  abort the current bank read.
REQ-013 out_rdy  in  1  consumer ready.
REQ-014 out_val  out  1  read stream valid.
REQ-015 rd_en  out  1  SRAM read strobe.
REQ-016 rd_addr  out  ADDR_W  SRAM word address.
REQ-017 beat_idx_d  out  3  beat index of the SRAM data returned this cycle.
REQ-018 bank_id  out  BANK_W  bank currently being read.
REQ-019 bank_done  out  1  pulse: current bank finished or aborted.
REQ-020 all_done  out  1  level: all passes complete.
REQ-021 state  out  2  FSM state.

Function
REQ-022 start SHALL register cfg_* into internal copies; only the internal copies SHALL be used thereafter.
REQ-023 FSM states SHALL be IDLE=00, READY=01, READ=11.
REQ-024 start SHALL force the next state to IDLE from any state; start has priority over all other inputs.
REQ-025 IDLE->READY SHALL occur when bank_prepare has been high this cycle and the previous cycle, all_done=0, and start=0.
REQ-026 READY->READ SHALL occur when out_rdy=1; READY SHALL hold otherwise.
REQ-027 READY or READ->IDLE SHALL occur on bank_done.
REQ-028 adv SHALL be defined as out_rdy & (state is READY or READ) & !start.
REQ-029 out_val SHALL equal (state==READ).
REQ-030 rd_en SHALL equal adv & (beat_cnt==0).
REQ-031 On adv, beat_cnt SHALL increment; when beat_cnt==BEATS-1 it SHALL wrap to 0 and rd_addr SHALL increment.
REQ-032 When BEATS=1, beat_cnt SHALL stay 0 and every adv SHALL assert rd_en.
REQ-033 bank_done SHALL be combinational: (adv & rd_addr==last_addr & beat_cnt==BEATS-1) | (pull_back & state!=IDLE).
REQ-034 In IDLE and the cycle after bank_done, rd_addr and beat_cnt SHALL return to 0.
REQ-035 beat_idx_d SHALL be beat_cnt registered on adv, giving 1-cycle alignment with SRAM read data.
REQ-036 On bank_done, bank_id SHALL increment modulo bank_num.
REQ-037 When bank_id wraps to 0, the pass counter SHALL increment.
REQ-038 When the final bank of pass cyc_num-1 completes, all_done SHALL set and hold until start or rst.
REQ-039 A pull_back-terminated bank SHALL count as completed for rotation.
REQ-040 start SHALL clear bank_id, the pass counter, all_done, rd_addr and beat_cnt.
REQ-041 bank_done and start in the same cycle: start SHALL win, and no rotation advance SHALL occur.
REQ-042 Internal counters SHALL be sized so that rd_addr == last_addr == 2^ADDR_W-1 terminates without wrap ambiguity.

Reset
REQ-043 rst SHALL act at the clock edge: state=IDLE; rd_addr, beat_cnt, beat_idx_d, bank_id, pass counter and all_done = 0; internal config = bank_num 1, cyc_num 1, last_addr 0.
REQ-044 rst asserted mid-read SHALL abort the read without a bank_done pulse; rst SHALL have priority over start.

Verification
REQ-045 BEATS=2, last_addr=3, out_rdy=1, bank_prepare held -> IDLE 2 cycles, READY 1, READ; rd_en on 4 alternate cycles at addr 0..3; bank_done on the 8th adv.
REQ-046 out_rdy toggles 1010 during READ -> rd_addr and beat_cnt frozen on 0 cycles; same 4 reads, no skipped or duplicated beat.
REQ-047 bank_num=3, cyc_num=2 -> bank_id sequence 0,1,2,0,1,2; all_done rises after the 6th bank_done; bank_prepare then ignored.
REQ-048 pull_back at addr 1 -> bank_done that cycle; next cycle IDLE, rd_addr 0, bank_id+1.
REQ-049 start during READ with new cfg -> next cycle IDLE, counters 0, new cfg used by the next bank.
REQ-050 BEATS=1, last_addr=0, bank_prepare and out_rdy high -> single rd_en in READY; bank_done that cycle; READY->IDLE.
